// File: rtl/led_pkg.sv
// Shared encodings for the LED shift sequencer: mode and speed codes,
// load patterns and small next-state helpers.
package led_pkg;

  localparam logic [1:0] MODE_ROT_LEFT  = 2'd0;
  localparam logic [1:0] MODE_ROT_RIGHT = 2'd1;
  localparam logic [1:0] MODE_PING_PONG = 2'd2;
  localparam logic [1:0] MODE_PAUSE     = 2'd3;

  localparam logic [1:0] SPEED_1S    = 2'd0;
  localparam logic [1:0] SPEED_500MS = 2'd1;
  localparam logic [1:0] SPEED_250MS = 2'd2;

  localparam logic [7:0] PAT_ROT = 8'h1F;
  localparam logic [7:0] PAT_PP  = 8'h01;

  function automatic logic [1:0] next_mode(input logic [1:0] cur);
    return cur + 2'd1;
  endfunction

  function automatic logic [1:0] next_speed(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      SPEED_1S:    nxt = SPEED_500MS;
      SPEED_500MS: nxt = SPEED_250MS;
      default:     nxt = SPEED_1S;
    endcase
    return nxt;
  endfunction

  // A zero period (tiny clk_freq) is clamped to 1 so the counter still wraps.
  function automatic logic [31:0] tick_period(input logic [31:0] clk_freq,
                                              input logic [1:0]  spd);
    logic [31:0] p;
    case (spd)
      SPEED_1S:    p = clk_freq;
      SPEED_500MS: p = clk_freq >> 1;
      default:     p = clk_freq >> 2;
    endcase
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, counting debouncer and a
// single-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q >= CNT_LAST) begin
      cnt_d   = {CW{1'b0}};
      level_d = ~level_q;
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
    press_d = level_d & ~level_q;
  end

  // Synchronizer and debounce state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_shift_sequencer.sv
// Control sequencer for an 8-bit LED shifter: mode FSM, rate tick and
// ping-pong direction tracking, driven by two debounced buttons.
module led_shift_sequencer #(
  parameter int CLK_FREQ        = 25_000_000,
  parameter int DEBOUNCE_CYCLES = CLK_FREQ / 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_speed,
  output logic       shift_en,
  output logic       shift_dir,
  output logic       load,
  output logic [7:0] load_value,
  output logic [1:0] mode,
  output logic [1:0] speed
);
  import led_pkg::*;

  localparam logic [31:0] CLK_FREQ_W = 32'(CLK_FREQ);

  logic        mode_press_s, speed_press_s;
  logic        start_q, start_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  speed_q, speed_d;
  logic        load_q, load_d;
  logic [7:0]  load_value_q, load_value_d;
  logic        shift_en_q, shift_en_d;
  logic        shift_dir_q, shift_dir_d;
  logic [2:0]  pos_q, pos_d;
  logic [31:0] tick_q, tick_d;
  logic [31:0] period_s;
  logic        pp_dir_s, dir_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .btn_raw(btn_mode), .press(mode_press_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
    .clk(clk), .rst(rst), .btn_raw(btn_speed), .press(speed_press_s)
  );

  // Next mode/speed, tick counter, load and shift generation.
  always_comb begin
    start_d      = 1'b0;
    speed_d      = speed_press_s ? next_speed(speed_q) : speed_q;
    mode_d       = mode_press_s ? next_mode(mode_q) : mode_q;
    load_d       = start_q | (mode_press_s & (mode_d != MODE_PAUSE));
    period_s     = tick_period(CLK_FREQ_W, speed_d);
    load_value_d = load_value_q;
    tick_d       = tick_q;
    shift_en_d   = 1'b0;

    // A load or speed change restarts the period and swallows any tick.
    if (load_d) begin
      tick_d       = 32'd0;
      load_value_d = (mode_d == MODE_PING_PONG) ? PAT_PP : PAT_ROT;
    end else if (speed_press_s) begin
      tick_d = 32'd0;
    end else if (mode_d == MODE_PAUSE) begin
      tick_d = tick_q;
    end else if (tick_q >= period_s - 32'd1) begin
      tick_d     = 32'd0;
      shift_en_d = 1'b1;
    end else begin
      tick_d = tick_q + 32'd1;
    end
  end

  // Direction: fixed in rotate modes, bounces at the ends in ping-pong.
  always_comb begin
    if (pos_q == 3'd7) begin
      pp_dir_s = 1'b1;
    end else if (pos_q == 3'd0) begin
      pp_dir_s = 1'b0;
    end else begin
      pp_dir_s = shift_dir_q;
    end

    case (mode_d)
      MODE_ROT_LEFT:  dir_s = 1'b0;
      MODE_ROT_RIGHT: dir_s = 1'b1;
      MODE_PING_PONG: dir_s = load_d ? 1'b0 : pp_dir_s;
      default:        dir_s = shift_dir_q;
    endcase
    shift_dir_d = dir_s;

    if (load_d) begin
      pos_d = 3'd0;
    end else if (shift_en_d && (mode_d == MODE_PING_PONG)) begin
      pos_d = dir_s ? (pos_q - 3'd1) : (pos_q + 3'd1);
    end else begin
      pos_d = pos_q;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q      <= 1'b1;
      mode_q       <= MODE_ROT_LEFT;
      speed_q      <= SPEED_250MS;
      load_q       <= 1'b0;
      load_value_q <= PAT_ROT;
      shift_en_q   <= 1'b0;
      shift_dir_q  <= 1'b0;
      pos_q        <= 3'd0;
      tick_q       <= 32'd0;
    end else begin
      start_q      <= start_d;
      mode_q       <= mode_d;
      speed_q      <= speed_d;
      load_q       <= load_d;
      load_value_q <= load_value_d;
      shift_en_q   <= shift_en_d;
      shift_dir_q  <= shift_dir_d;
      pos_q        <= pos_d;
      tick_q       <= tick_d;
    end
  end

  assign shift_en   = shift_en_q;
  assign shift_dir  = shift_dir_q;
  assign load       = load_q;
  assign load_value = load_value_q;
  assign mode       = mode_q;
  assign speed      = speed_q;

endmodule

// File: tb/tb_led_shift_sequencer.sv
// Directed bench for led_shift_sequencer: expected load/shift events are
// queued with their cycle number and matched against the DUT each cycle.
module tb_led_shift_sequencer;

  localparam int CLK_FREQ = 8;
  localparam int DEB      = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_speed = 1'b0;
  logic       shift_en, shift_dir, load;
  logic [7:0] load_value;
  logic [1:0] mode, speed;

  led_shift_sequencer #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_speed(btn_speed),
    .shift_en(shift_en), .shift_dir(shift_dir), .load(load),
    .load_value(load_value), .mode(mode), .speed(speed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ld;
    logic       se;
    logic [7:0] val;
    logic       dir;
    logic [1:0] md;
    logic [1:0] spd;
  } ev_t;

  typedef struct {
    int  cyc;
    ev_t ev;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  ev_t  got, want;
  logic exp_hit;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Event monitor: every cycle with an observed or expected event is compared.
  always @(negedge clk) begin
    if (!rst && cyc > 0) begin
      exp_hit = (sb.size() > 0) && (sb[0].cyc == cyc);
      if (exp_hit || load || shift_en) begin
        got  = (load || shift_en) ? {load, shift_en, load_value, shift_dir, mode, speed} : '0;
        want = exp_hit ? sb[0].ev : '0;
        if (exp_hit) void'(sb.pop_front());
        vectors++;
        assert (got === want) else begin
          miscompares++;
          $error("FAIL event cyc=%0d observed=%h expected=%h", cyc, got, want);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout cyc=%0d observed=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  task automatic push(input int c, input logic ld, input logic se, input logic [7:0] v,
                      input logic dir, input logic [1:0] m, input logic [1:0] s);
    exp_t e;
    e.cyc = c;
    e.ev  = {ld, se, v, dir, m, s};
    sb.push_back(e);
  endtask

  task automatic push_shifts(input int first, input int last, input int step, input logic [7:0] v,
                             input logic dir, input logic [1:0] m, input logic [1:0] s);
    for (int c = first; c <= last; c += step) push(c, 1'b0, 1'b1, v, dir, m, s);
  endtask

  task automatic hold_btn(input logic m, input logic s, input int n);
    btn_mode  = m;
    btn_speed = s;
    repeat (n) @(negedge clk);
    btn_mode  = 1'b0;
    btn_speed = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {18'd0, shift_en, load, load_value, mode, speed, shift_dir},
          {18'd0, 1'b0, 1'b0, 8'h1F, 2'd0, 2'd2, 1'b0});

    // Release: load at cycle 1, shifts every 2 cycles at speed 2.
    push(1, 1'b1, 1'b0, 8'h1F, 1'b0, 2'd0, 2'd2);
    push_shifts(3, 15, 2, 8'h1F, 1'b0, 2'd0, 2'd2);
    rst = 1'b0;

    // Speed held 6 cycles: one press at cycle 17, next shift 8 cycles later.
    wait_cyc(10);
    push_shifts(25, 49, 8, 8'h1F, 1'b0, 2'd0, 2'd0);
    hold_btn(1'b0, 1'b1, 6);

    // 3-cycle glitch must be rejected.
    wait_cyc(30);
    hold_btn(1'b0, 1'b1, 3);
    wait_cyc(45);
    check("glitch_speed", {30'd0, speed}, {30'd0, 2'd0});

    // Mode press into ROT_RIGHT, then into PING_PONG.
    wait_cyc(50);
    push(57, 1'b1, 1'b0, 8'h1F, 1'b1, 2'd1, 2'd0);
    push(65, 1'b0, 1'b1, 8'h1F, 1'b1, 2'd1, 2'd0);
    hold_btn(1'b1, 1'b0, 6);
    wait_cyc(64);
    push(71, 1'b1, 1'b0, 8'h01, 1'b0, 2'd2, 2'd0);
    push_shifts(79, 127, 8, 8'h01, 1'b0, 2'd2, 2'd0);
    push_shifts(135, 183, 8, 8'h01, 1'b1, 2'd2, 2'd0);
    push_shifts(191, 199, 8, 8'h01, 1'b0, 2'd2, 2'd0);
    hold_btn(1'b1, 1'b0, 6);

    // Into PAUSE at cycle 202: no loads, no shifts, pattern held.
    wait_cyc(195);
    hold_btn(1'b1, 1'b0, 6);
    wait_cyc(227);
    check("pause_hold", {22'd0, mode, load_value}, {22'd0, 2'd3, 8'h01});
    check("queue_drained_1", sb.size(), 32'd0);

    // Reset mid-count in PAUSE with a mode press still debouncing.
    btn_mode = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst      = 1'b1;
    btn_mode = 1'b0;
    #1;
    check("async_reset", {18'd0, shift_en, load, load_value, mode, speed, shift_dir},
          {18'd0, 1'b0, 1'b0, 8'h1F, 2'd0, 2'd2, 1'b0});
    repeat (2) @(negedge clk);
    check("reset_hold", {18'd0, shift_en, load, load_value, mode, speed, shift_dir},
          {18'd0, 1'b0, 1'b0, 8'h1F, 2'd0, 2'd2, 1'b0});

    // Reload after release, then simultaneous mode+speed press at cycle 17.
    push(1, 1'b1, 1'b0, 8'h1F, 1'b0, 2'd0, 2'd2);
    push_shifts(3, 15, 2, 8'h1F, 1'b0, 2'd0, 2'd2);
    push(17, 1'b1, 1'b0, 8'h1F, 1'b1, 2'd1, 2'd0);
    push_shifts(25, 41, 8, 8'h1F, 1'b1, 2'd1, 2'd0);
    rst = 1'b0;
    wait_cyc(10);
    hold_btn(1'b1, 1'b1, 6);
    wait_cyc(45);
    check("queue_drained_2", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
